// File: rtl/crypt_round_sequencer.sv
// Round sequencer for the S-LUT round datapath.
// Takes one block per input handshake, walks the datapath through a load
// cycle and NUM_ROUNDS keyed rounds, captures the final state and presents
// it on an output handshake. GLOBAL_EN freezes the processing side while the
// output handshake stays live.
module crypt_round_sequencer #(
    parameter int NUM_ROUNDS = 3,
    parameter int LUT_LAT    = 1,
    parameter int DATA_W     = 32,
    localparam int RW        = $clog2(NUM_ROUNDS + 1),
    localparam int WW        = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              GLOBAL_EN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] CipherText,
    output logic [DATA_W-1:0] DP_DATA,
    output logic              Sel,
    output logic              EN,
    output logic [RW-1:0]     ROUND,
    input  logic [DATA_W-1:0] DP_RESULT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] PlainText,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [WW-1:0] WAIT_INIT  = WW'(LUT_LAT - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
    localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

    state_t             state_reg, state_next;
    logic [RW-1:0]      round_reg, round_next;
    logic [WW-1:0]      wait_reg, wait_next;
    logic [DATA_W-1:0]  dp_data_reg, dp_data_next;
    logic [DATA_W-1:0]  plain_reg, plain_next;
    // Keeps IN_READY low through reset and for the first edge after release,
    // so no block can be taken on the reset-recovery edge.
    logic               armed_reg;

    // State, counters and data registers; everything clears on async reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            round_reg   <= '0;
            wait_reg    <= '0;
            dp_data_reg <= '0;
            plain_reg   <= '0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            round_reg   <= round_next;
            wait_reg    <= wait_next;
            dp_data_reg <= dp_data_next;
            plain_reg   <= plain_next;
            armed_reg   <= 1'b1;
        end
    end

    // Next-state and datapath control decode. Outside DONE a low GLOBAL_EN
    // leaves every *_next equal to its register and suppresses EN.
    always_comb begin
        state_next   = state_reg;
        round_next   = round_reg;
        wait_next    = wait_reg;
        dp_data_next = dp_data_reg;
        plain_next   = plain_reg;
        IN_READY     = 1'b0;
        Sel          = 1'b0;
        EN           = 1'b0;
        ROUND        = '0;
        OUT_VALID    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                IN_READY = GLOBAL_EN & armed_reg;
                if (GLOBAL_EN && armed_reg && IN_VALID) begin
                    dp_data_next = CipherText;
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                Sel = 1'b1;
                EN  = GLOBAL_EN;
                if (GLOBAL_EN) begin
                    round_next = FIRST_ROUND;
                    wait_next  = WAIT_INIT;
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                ROUND = round_reg;
                if (GLOBAL_EN) begin
                    if (wait_reg == '0) begin
                        // Last cycle of this round: datapath commits its output.
                        EN = 1'b1;
                        if (round_reg < LAST_ROUND) begin
                            round_next = RW'(round_reg + 1'b1);
                            wait_next  = WAIT_INIT;
                        end else begin
                            state_next = ST_CAPTURE;
                        end
                    end else begin
                        wait_next = wait_reg - 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (GLOBAL_EN) begin
                    plain_next = DP_RESULT;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Output side is never frozen; handshake completes regardless of GLOBAL_EN.
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign BUSY      = (state_reg != ST_IDLE);
    assign DP_DATA   = dp_data_reg;
    assign PlainText = plain_reg;

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// Self-checking bench for crypt_round_sequencer: one instance with LUT_LAT=1
// and one with LUT_LAT=2, each driving a behavioural S-LUT datapath model.
module tb_crypt_round_sequencer;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        global_en [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] ct        [2];
    logic [31:0] dp_data   [2];
    logic        sel       [2];
    logic        en        [2];
    logic [1:0]  round     [2];
    logic [31:0] dp_result [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] pt        [2];
    logic        busy      [2];
    logic [31:0] dp_state  [2];

    int checks = 0;
    int errors = 0;

    logic       q_sel   [$];
    logic       q_en    [$];
    logic [1:0] q_round [$];
    int         col_lat;
    int         col_en;

    always #5 clk = ~clk;

    crypt_round_sequencer #(.NUM_ROUNDS(N), .LUT_LAT(1), .DATA_W(32)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .GLOBAL_EN(global_en[0]),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .CipherText(ct[0]),
        .DP_DATA(dp_data[0]), .Sel(sel[0]), .EN(en[0]), .ROUND(round[0]),
        .DP_RESULT(dp_result[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .PlainText(pt[0]), .BUSY(busy[0])
    );

    crypt_round_sequencer #(.NUM_ROUNDS(N), .LUT_LAT(2), .DATA_W(32)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .GLOBAL_EN(global_en[1]),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .CipherText(ct[1]),
        .DP_DATA(dp_data[1]), .Sel(sel[1]), .EN(en[1]), .ROUND(round[1]),
        .DP_RESULT(dp_result[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .PlainText(pt[1]), .BUSY(busy[1])
    );

    // Datapath model: load on Sel, otherwise xor the round index into every byte.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en[k] === 1'b1)
                dp_state[k] <= sel[k] ? dp_data[k] : (dp_state[k] ^ {4{{6'b0, round[k]}}});
        end
    end
    assign dp_result[0] = dp_state[0];
    assign dp_result[1] = dp_state[1];

    // Reference: the block xored with every round key byte 1..N in turn.
    function automatic logic [31:0] ref_plain(input logic [31:0] c);
        logic [31:0] x;
        logic [7:0]  b;
        x = c;
        for (int r = 1; r <= N; r++) begin
            b = 8'(r);
            x = x ^ {b, b, b, b};
        end
        return x;
    endfunction

    // Expected controls for cycle k after the accepting edge (k=0 is the load).
    function automatic void exp_ctrl(input int k, input int l, output logic s,
                                     output logic e, output logic [1:0] r);
        if (k == 0) begin
            s = 1'b1; e = 1'b1; r = 2'd0;
        end else if (k <= N * l) begin
            s = 1'b0;
            r = 2'((k - 1) / l + 1);
            e = (((k - 1) % l) == (l - 1));
        end else begin
            s = 1'b0; e = 1'b0; r = 2'd0;
        end
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int u, input logic [31:0] c);
        int n;
        n = 0;
        ct[u] = c;
        in_valid[u] = 1'b1;
        while (in_ready[u] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        in_valid[u] = 1'b0;
    endtask

    // Records Sel/EN/ROUND per cycle from the load cycle until OUT_VALID.
    task automatic collect(input int u);
        q_sel.delete(); q_en.delete(); q_round.delete();
        col_lat = 0;
        col_en  = 0;
        while (out_valid[u] !== 1'b1 && col_lat < 200) begin
            q_sel.push_back(sel[u]);
            q_en.push_back(en[u]);
            q_round.push_back(round[u]);
            if (en[u] === 1'b1) col_en++;
            step();
            col_lat++;
        end
        if (out_valid[u] !== 1'b1) col_lat = -1;
    endtask

    task automatic release_out(input int u);
        out_ready[u] = 1'b1;
        step();
        out_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] c;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({in_ready[u], sel[u], en[u], round[u], out_valid[u], busy[u]} !== 7'd0 ||
                dp_data[u] !== 32'd0 || pt[u] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state u%0d: got ctrl=%b dp=%h pt=%h expected all zero", u,
                         {in_ready[u], sel[u], en[u], round[u], out_valid[u], busy[u]}, dp_data[u], pt[u]);
            end
        end
        step(); step();
        rst_n = 1'b1;
        step();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (in_ready[u] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset u%0d: got %b expected 1", u, in_ready[u]);
            end
        end
        // Abandon a block in the middle of round 2.
        c = $urandom;
        accept(0, c);
        step(); step();
        checks++;
        if (round[0] !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_round: got %0d expected 2", round[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready[0], sel[0], en[0], round[0], out_valid[0], busy[0]} !== 7'd0 ||
            dp_data[0] !== 32'd0 || pt[0] !== 32'd0) begin
            errors++;
            $display("FAIL midblock_reset: got ctrl=%b dp=%h pt=%h expected all zero",
                     {in_ready[0], sel[0], en[0], round[0], out_valid[0], busy[0]}, dp_data[0], pt[0]);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_midreset: got %b expected 1", in_ready[0]);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL no_output_after_reset cycle%0d: got valid=%b busy=%b expected 0 0", i, out_valid[0], busy[0]);
            end
            step();
        end
    endtask

    task automatic check_block(input int u, input logic [31:0] c, input string tag);
        logic s, e;
        logic [1:0] r;
        int l;
        l = lat_of(u);
        checks++;
        if (col_lat != N * l + 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", tag, col_lat, N * l + 2);
        end
        for (int k = 0; k < q_sel.size(); k++) begin
            exp_ctrl(k, l, s, e, r);
            checks++;
            if (q_sel[k] !== s || q_en[k] !== e || q_round[k] !== r) begin
                errors++;
                $display("FAIL %s_ctrl_cycle%0d: got sel=%b en=%b round=%0d expected sel=%b en=%b round=%0d",
                         tag, k, q_sel[k], q_en[k], q_round[k], s, e, r);
            end
        end
        checks++;
        if (col_en != N + 1) begin
            errors++;
            $display("FAIL %s_en_count: got %0d expected %0d", tag, col_en, N + 1);
        end
        checks++;
        if (pt[u] !== ref_plain(c)) begin
            errors++;
            $display("FAIL %s_plaintext: got %h expected %h", tag, pt[u], ref_plain(c));
        end
        $display("block %s unit=%0d ct=%h pt=%h lat=%0d", tag, u, c, pt[u], col_lat);
    endtask

    task automatic test_defaults();
        accept(0, 32'hAAAAAAAA);
        checks++;
        if (dp_data[0] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL dp_data: got %h expected %h", dp_data[0], 32'hAAAAAAAA);
        end
        collect(0);
        check_block(0, 32'hAAAAAAAA, "defaults");
        release_out(0);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL defaults_release: got valid=%b busy=%b expected 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_lut_lat2();
        logic [31:0] c;
        c = $urandom;
        accept(1, c);
        collect(1);
        check_block(1, c, "lutlat2");
        release_out(1);
    endtask

    task automatic test_out_stall();
        logic [31:0] a, b, held;
        a = $urandom;
        b = $urandom;
        accept(0, a);
        collect(0);
        check_block(0, a, "stall_first");
        held = pt[0];
        ct[0] = b;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || pt[0] !== held || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle%0d: got valid=%b pt=%h ready=%b expected 1 %h 0",
                         i, out_valid[0], pt[0], in_ready[0], held);
            end
            step();
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_turnaround: got ready=%b valid=%b expected 1 0", in_ready[0], out_valid[0]);
        end
        step();
        in_valid[0] = 1'b0;
        checks++;
        if (sel[0] !== 1'b1 || en[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_second_accept: got sel=%b en=%b expected 1 1", sel[0], en[0]);
        end
        collect(0);
        check_block(0, b, "stall_second");
        release_out(0);
    endtask

    task automatic test_freeze();
        logic [31:0] c;
        int lat;
        c = $urandom;
        accept(0, c);
        step(); step();
        lat = 2;
        checks++;
        if (round[0] !== 2'd2) begin
            errors++;
            $display("FAIL freeze_entry_round: got %0d expected 2", round[0]);
        end
        for (int i = 0; i < 4; i++) begin
            global_en[0] = 1'b0;
            #1;
            checks++;
            if (en[0] !== 1'b0 || round[0] !== 2'd2 || sel[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL freeze_cycle%0d: got en=%b round=%0d sel=%b busy=%b expected 0 2 0 1",
                         i, en[0], round[0], sel[0], busy[0]);
            end
            step();
            lat++;
        end
        global_en[0] = 1'b1;
        while (out_valid[0] !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        checks++;
        if (lat != N + 2 + 4) begin
            errors++;
            $display("FAIL freeze_latency: got %0d expected %0d", lat, N + 2 + 4);
        end
        checks++;
        if (pt[0] !== ref_plain(c)) begin
            errors++;
            $display("FAIL freeze_plaintext: got %h expected %h", pt[0], ref_plain(c));
        end
        $display("block freeze unit=0 ct=%h pt=%h lat=%0d", c, pt[0], lat);
        release_out(0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] results [$];
        int acc_cyc [2];
        int accepts, en_total, cyc;
        logic acc;
        accepts = 0; en_total = 0; cyc = 0;
        ct[0] = 32'h00000000;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        while (results.size() < 2 && cyc < 100) begin
            if (en[0] === 1'b1) en_total++;
            acc = (in_valid[0] === 1'b1) && (in_ready[0] === 1'b1);
            if (out_valid[0] === 1'b1) results.push_back(pt[0]);
            if (acc && accepts < 2) begin
                acc_cyc[accepts] = cyc;
                accepts++;
            end
            step();
            cyc++;
            if (acc) begin
                if (accepts == 1) ct[0] = 32'hFFFFFFFF;
                else in_valid[0] = 1'b0;
            end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        checks++;
        if (results.size() != 2 || accepts != 2) begin
            errors++;
            $display("FAIL b2b_count: got results=%0d accepts=%0d expected 2 2", results.size(), accepts);
        end else begin
            checks++;
            if (results[0] !== ref_plain(32'h00000000)) begin
                errors++;
                $display("FAIL b2b_first: got %h expected %h", results[0], ref_plain(32'h00000000));
            end
            checks++;
            if (results[1] !== ref_plain(32'hFFFFFFFF)) begin
                errors++;
                $display("FAIL b2b_second: got %h expected %h", results[1], ref_plain(32'hFFFFFFFF));
            end
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != N + 4) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], N + 4);
            end
            $display("block b2b unit=0 pt0=%h pt1=%h spacing=%0d", results[0], results[1], acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (en_total != 2 * (N + 1)) begin
            errors++;
            $display("FAIL b2b_en_total: got %0d expected %0d", en_total, 2 * (N + 1));
        end
    endtask

    task automatic test_random();
        int u, d;
        logic [31:0] c, held;
        for (int i = 0; i < 8; i++) begin
            u = $urandom_range(0, 1);
            c = $urandom;
            d = $urandom_range(0, 3);
            accept(u, c);
            collect(u);
            check_block(u, c, "random");
            held = pt[u];
            for (int j = 0; j < d; j++) begin
                step();
                checks++;
                if (out_valid[u] !== 1'b1 || pt[u] !== held) begin
                    errors++;
                    $display("FAIL random_hold: got valid=%b pt=%h expected 1 %h", out_valid[u], pt[u], held);
                end
            end
            release_out(u);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            global_en[u] = 1'b1;
            in_valid[u]  = 1'b0;
            ct[u]        = 32'd0;
            out_ready[u] = 1'b0;
        end
        #2;
        test_reset();
        test_defaults();
        test_lut_lat2();
        test_out_stall();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
